pipe_mem_stage: RTL

- MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM register.
- Consumes the EX/MEM outputs and performs the data-memory access.
- Supports a configurable number of wait states, with a stall handshake back to upstream stages.
- Registers the results into a MEM/WB register that feeds writeback.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_dmem.sv | 32 +++
 rtl/pipe_mem_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline MEM stage: data widths, the MEM-stage
// wait-state FSM encoding, and the MEM/WB register layout with its bubble value.
package pipe_pkg;

   localparam int WORD_W = 32;
   localparam int REG_W  = 5;

   typedef enum logic {
      IDLE,
      WAIT
   } mem_state_e;

   typedef struct packed {
      logic              wreg;
      logic              m2reg;
      logic [WORD_W-1:0] mo;
      logic [WORD_W-1:0] alu;
      logic [REG_W-1:0]  rn;
      logic              exc;
   } memwb_t;

   // Reset value of the MEM/WB register; its control fields double as the
   // bubble injected on stall cycles.
   localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/pipe_dmem.sv
// Data memory: DEPTH x WORD_W array, asynchronous read, synchronous write.
// Contents are not reset.
// Ports:
//   clk    rising-edge clock
//   we     write enable, commits wdata to mem[addr] at the posedge
//   addr   word index
//   wdata  write data
//   rdata  asynchronous read data of mem[addr] (pre-write value)
module pipe_dmem
   import pipe_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage of the 5-stage pipeline: data-memory access with optional wait
// states, stall handshake to upstream, and the MEM/WB register.
// Optional feature macro: PIPE_MEM_ALIGN_CHK_EN (misaligned access flag,
// store suppression and load squash). Without it mexc is tied to 0.
// Ports:
//   clk, clr                     clock, synchronous active-high reset
//   mwreg, mm2reg, mwmem         EX/MEM control (reg write, load, store)
//   malu, mb, mrn                EX/MEM address/ALU result, store data, dest reg
//   stall                        upstream must hold while 1
//   wwreg, wm2reg, wmo, walu, wrn MEM/WB register outputs
//   mexc                         misaligned-access flag
//
// state | meaning
// IDLE  | no access pending; commits at once unless an access needs wait states
// WAIT  | counting wait states down; commits when the counter reaches 0
module pipe_mem_stage
   import pipe_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              mwreg,
   input  logic              mm2reg,
   input  logic              mwmem,
   input  logic [WORD_W-1:0] malu,
   input  logic [WORD_W-1:0] mb,
   input  logic [REG_W-1:0]  mrn,
   output logic              stall,
   output logic              wwreg,
   output logic              wm2reg,
   output logic [WORD_W-1:0] wmo,
   output logic [WORD_W-1:0] walu,
   output logic [REG_W-1:0]  wrn,
   output logic              mexc
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   mem_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   memwb_t            memwb_q, memwb_d;

   logic              acc;
   logic              commit;
   logic              mis;
   logic              mem_we;
   logic [AW-1:0]     idx;
   logic [WORD_W-1:0] rdata;
   logic              unused_addr_bits;

   assign acc = mwmem | mm2reg;
   assign idx = malu[AW+1:2];
   assign unused_addr_bits = ^{malu[WORD_W-1:AW+2], malu[1:0]};

`ifdef PIPE_MEM_ALIGN_CHK_EN
   assign mis = acc & (malu[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      if (WAIT_CYCLES == 0) begin
         commit = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (acc) begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end else begin
                  commit = 1'b1;
               end
            end
            WAIT: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - 1'b1;
               end else begin
                  commit  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Reset overrides everything: no write, no stall while clr is high.
   assign stall  = ~commit & ~clr;
   assign mem_we = commit & mwmem & ~mis & ~clr;

   always_comb begin
      memwb_d = memwb_q;
      if (commit) begin
         memwb_d.wreg  = mwreg & ~mis;
         memwb_d.m2reg = mm2reg;
         memwb_d.mo    = rdata;
         memwb_d.alu   = malu;
         memwb_d.rn    = mrn;
         memwb_d.exc   = mis;
      end else begin
         // Bubble: control fields cleared, data fields hold.
         memwb_d.wreg  = MEMWB_BUBBLE.wreg;
         memwb_d.m2reg = MEMWB_BUBBLE.m2reg;
         memwb_d.rn    = MEMWB_BUBBLE.rn;
         memwb_d.exc   = MEMWB_BUBBLE.exc;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         memwb_q <= MEMWB_BUBBLE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         memwb_q <= memwb_d;
      end
   end

   pipe_dmem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_dmem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (idx),
      .wdata (mb),
      .rdata (rdata)
   );

   assign wwreg  = memwb_q.wreg;
   assign wm2reg = memwb_q.m2reg;
   assign wmo    = memwb_q.mo;
   assign walu   = memwb_q.alu;
   assign wrn    = memwb_q.rn;
   assign mexc   = memwb_q.exc;

endmodule
